// File: rtl/rock_pkg.sv
// Shared types and helpers for the rocking-search controller and motion generator.
package rock_pkg;

  // Widest sensor and level widths the helpers support; callers cast in and out.
  localparam int MAX_DATA_W  = 16;
  localparam int MAX_LEVEL_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    CALM    = 3'd3,
    ERROR   = 3'd4
  } state_t;

  typedef struct packed {
    logic [MAX_LEVEL_W-1:0] a;
    logic [MAX_LEVEL_W-1:0] f;
    logic                   wrap;
  } af_step_t;

  // Unsigned stress: one extra bit so the sum never overflows.
  function automatic logic [MAX_DATA_W:0] stress_f(input logic [MAX_DATA_W-1:0] cry,
                                                   input logic [MAX_DATA_W-1:0] hr);
    return {1'b0, cry} + {1'b0, hr};
  endfunction

  // Frequency is the fast axis, amplitude the slow one; past (max,max) the
  // walk restarts at (1,1) and flags the wrap.
  function automatic af_step_t next_setting(input logic [MAX_LEVEL_W-1:0] a,
                                            input logic [MAX_LEVEL_W-1:0] f,
                                            input logic [MAX_LEVEL_W-1:0] mx);
    af_step_t r;
    r.a    = a;
    r.f    = f;
    r.wrap = 1'b0;
    if (f < mx) begin
      r.f = f + 1'b1;
    end else if (a < mx) begin
      r.a = a + 1'b1;
      r.f = MAX_LEVEL_W'(1);
    end else begin
      r.a    = MAX_LEVEL_W'(1);
      r.f    = MAX_LEVEL_W'(1);
      r.wrap = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rock_search_ctrl_af_stepper.sv
// Registered amplitude/frequency grid counter: clear to off, start at (1,1), or step.
module af_stepper
  import rock_pkg::*;
#(
  parameter int LEVEL_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               init,
  input  logic               step,
  output logic [LEVEL_W-1:0] a,
  output logic [LEVEL_W-1:0] f,
  output logic               wrap
);

  localparam logic [MAX_LEVEL_W-1:0] LVL_MAX = MAX_LEVEL_W'((1 << LEVEL_W) - 1);

  af_step_t ns;

  // Next grid point and whether the current point is the last one.
  always_comb begin
    ns = next_setting(MAX_LEVEL_W'(a), MAX_LEVEL_W'(f), LVL_MAX);
  end

  assign wrap = ns.wrap;

  // Level registers; clear dominates init, init dominates step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a <= '0;
      f <= '0;
    end else if (clr) begin
      a <= '0;
      f <= '0;
    end else if (init) begin
      a <= LEVEL_W'(1);
      f <= LEVEL_W'(1);
    end else if (step) begin
      a <= LEVEL_W'(ns.a);
      f <= LEVEL_W'(ns.f);
    end
  end

endmodule

// File: rtl/rock_search_ctrl.sv
// Searches the A x F rocking grid for a setting that lowers fused cry/heart stress.
module rock_search_ctrl
  import rock_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int LEVEL_W     = 3,
  parameter int SETTLE_CYC  = 1024,
  parameter int DROP_MIN    = 4,
  parameter int CALM_THRESH = 16,
  parameter int MAX_PASSES  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [DATA_W-1:0]  huilVolume,
  input  logic [DATA_W-1:0]  hartRitme,
  output logic [LEVEL_W-1:0] A,
  output logic [LEVEL_W-1:0] F,
  output logic               calm,
  output logic               busy,
  output logic               error
);

  localparam int SET_W  = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam int PASS_W = $clog2(MAX_PASSES + 1);

  state_t              state, state_nxt;
  logic [DATA_W:0]     stress, stress_ref, ref_nxt;
  logic [SET_W-1:0]    settle_cnt, settle_nxt;
  logic [PASS_W-1:0]   pass_cnt, pass_nxt;
  logic                af_clr, af_init, af_step, af_wrap;
  logic                is_calm, improved;

  assign stress = (DATA_W+1)'(stress_f(MAX_DATA_W'(huilVolume), MAX_DATA_W'(hartRitme)));

  assign is_calm  = stress <= (DATA_W+1)'(CALM_THRESH);
  // One extra bit so stress + DROP_MIN cannot wrap.
  assign improved = ({1'b0, stress} + (DATA_W+2)'(DROP_MIN)) <= {1'b0, stress_ref};

  af_stepper #(.LEVEL_W(LEVEL_W)) u_af (
    .clk   (clk),
    .reset (reset),
    .clr   (af_clr),
    .init  (af_init),
    .step  (af_step),
    .a     (A),
    .f     (F),
    .wrap  (af_wrap)
  );

  // Next-state and search bookkeeping; samples outside IDLE/MEASURE/CALM fall through.
  always_comb begin
    state_nxt  = state;
    ref_nxt    = stress_ref;
    settle_nxt = settle_cnt;
    pass_nxt   = pass_cnt;
    af_clr     = 1'b0;
    af_init    = 1'b0;
    af_step    = 1'b0;
    case (state)
      IDLE, CALM: begin
        if (sample_valid) begin
          if (is_calm) begin
            state_nxt = CALM;
            af_clr    = 1'b1;
          end else begin
            state_nxt  = SETTLE;
            ref_nxt    = stress;
            settle_nxt = '0;
            pass_nxt   = '0;
            af_init    = 1'b1;
          end
        end
      end
      SETTLE: begin
        settle_nxt = settle_cnt + 1'b1;
        if (settle_cnt == SET_W'(SETTLE_CYC - 1)) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (sample_valid) begin
          if (is_calm) begin
            state_nxt = CALM;
            af_clr    = 1'b1;
          end else if (improved) begin
            state_nxt  = SETTLE;
            ref_nxt    = stress;
            pass_nxt   = '0;
            settle_nxt = '0;
          end else if (af_wrap && (pass_cnt == PASS_W'(MAX_PASSES - 1))) begin
            state_nxt = ERROR;
            af_clr    = 1'b1;
          end else begin
            state_nxt  = SETTLE;
            settle_nxt = '0;
            af_step    = 1'b1;
            if (af_wrap) pass_nxt = pass_cnt + 1'b1;
          end
        end
      end
      ERROR: begin
        af_clr = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        af_clr    = 1'b1;
      end
    endcase
  end

  // State, search registers and status flags decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      stress_ref <= '0;
      settle_cnt <= '0;
      pass_cnt   <= '0;
      calm       <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nxt;
      stress_ref <= ref_nxt;
      settle_cnt <= settle_nxt;
      pass_cnt   <= pass_nxt;
      calm       <= (state_nxt == CALM);
      busy       <= (state_nxt == SETTLE) || (state_nxt == MEASURE);
      error      <= (state_nxt == ERROR);
    end
  end

endmodule

// File: tb/tb_rock_search_ctrl.sv
// Directed bench for rock_search_ctrl with a small grid and short settle time.
module tb_rock_search_ctrl;

  localparam int DATA_W = 8;
  localparam int LEVEL_W = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               sample_valid = 1'b0;
  logic [DATA_W-1:0]  huilVolume = '0;
  logic [DATA_W-1:0]  hartRitme = '0;
  logic [LEVEL_W-1:0] A, F;
  logic               calm, busy, error;

  int n_chk = 0;
  int n_fail = 0;

  rock_search_ctrl #(
    .DATA_W(DATA_W), .LEVEL_W(LEVEL_W), .SETTLE_CYC(4),
    .DROP_MIN(2), .CALM_THRESH(10), .MAX_PASSES(1)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
    .huilVolume(huilVolume), .hartRitme(hartRitme),
    .A(A), .F(F), .calm(calm), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int v, input int h);
    huilVolume   = DATA_W'(v);
    hartRitme    = DATA_W'(h);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  task automatic chk_out(input string tag, input int ea, input int ef,
                         input int ecalm, input int ebusy, input int eerr);
    chk({tag, ".A"}, int'(A), ea);
    chk({tag, ".F"}, int'(F), ef);
    chk({tag, ".calm"}, int'(calm), ecalm);
    chk({tag, ".busy"}, int'(busy), ebusy);
    chk({tag, ".error"}, int'(error), eerr);
  endtask

  // Expected grid walk after (1,2): seven more steps, last one wraps into ERROR.
  int walk_a[7] = '{1, 2, 2, 2, 3, 3, 3};
  int walk_f[7] = '{3, 1, 2, 3, 1, 2, 3};

  initial begin
    // Reset and start
    reset = 1'b0;
    tick();
    tick();
    chk_out("rst", 0, 0, 0, 0, 0);
    reset = 1'b1;
    sample(30, 40);
    chk_out("start", 1, 1, 0, 1, 0);

    // Strobes during SETTLE, including its last cycle, are ignored
    sample(0, 0);
    chk_out("ign1", 1, 1, 0, 1, 0);
    tick();
    tick();
    sample(0, 0);
    chk_out("ign2", 1, 1, 0, 1, 0);

    // Improvement 70 -> 67 holds (1,1); 66 is not enough and advances
    sample(30, 37);
    chk_out("hold", 1, 1, 0, 1, 0);
    settle();
    sample(30, 36);
    chk_out("adv", 1, 2, 0, 1, 0);

    // Walk the rest of the grid without improvement
    for (int i = 0; i < 7; i++) begin
      settle();
      sample(30, 36);
      chk($sformatf("walk%0d.A", i), int'(A), walk_a[i]);
      chk($sformatf("walk%0d.F", i), int'(F), walk_f[i]);
    end
    settle();
    sample(30, 36);
    chk_out("err", 0, 0, 0, 0, 1);
    sample(0, 0);
    tick();
    sample(50, 50);
    chk_out("err_sticky", 0, 0, 0, 0, 1);

    // Reset clears ERROR; calm entry and restart from MEASURE
    reset = 1'b0;
    tick();
    chk_out("err_rst", 0, 0, 0, 0, 0);
    reset = 1'b1;
    sample(30, 40);
    settle();
    sample(5, 5);
    chk_out("calm", 0, 0, 1, 0, 0);
    sample(6, 5);
    chk_out("restart", 1, 1, 0, 1, 0);

    // Stress_ref is now 11; stress 11 never improves. Walk to (2,3).
    for (int i = 0; i < 5; i++) begin
      settle();
      sample(6, 5);
    end
    chk_out("at23", 2, 3, 0, 1, 0);
    tick();
    reset = 1'b0;
    tick();
    chk_out("mid_rst", 0, 0, 0, 0, 0);
    reset = 1'b1;

    // IDLE with a calm sample goes straight to CALM
    sample(3, 4);
    chk_out("idle_calm", 0, 0, 1, 0, 0);

    // Stress beyond DATA_W bits: 257 -> 250 is an improvement
    sample(129, 128);
    chk_out("wide_start", 1, 1, 0, 1, 0);
    settle();
    sample(125, 125);
    chk_out("wide_hold", 1, 1, 0, 1, 0);
    settle();
    sample(125, 124);
    chk_out("wide_adv", 1, 2, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
